// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART rate-select type
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_SET_9600    = 2'd0,
    BAUD_SET_115200  = 2'd1,
    BAUD_SET_460800  = 2'd2,
    BAUD_SET_1000000 = 2'd3
  } baud_set_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry holding register
// Bit timing is derived from the 16 MHz core clock via a per-frame latched period.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CNT_WIDTH = 11
) (
  input  logic       clk_16mhz,
  input  logic       rstn,
  input  baud_set_t  baud_setting,
  input  logic       rx,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic [1:0]           sync_q;
  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] per_d_q, per_d_d;
  logic [CNT_WIDTH-1:0] per_h_q, per_h_d;
  logic [CNT_WIDTH-1:0] sel_d, sel_h;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 ferr_q, ferr_d;

  assign rxs = sync_q[1];

  always_comb begin
    sel_d = CNT_WIDTH'(16);
    case (baud_setting)
      BAUD_SET_9600:    sel_d = CNT_WIDTH'(1667);
      BAUD_SET_115200:  sel_d = CNT_WIDTH'(139);
      BAUD_SET_460800:  sel_d = CNT_WIDTH'(35);
      BAUD_SET_1000000: sel_d = CNT_WIDTH'(16);
      default:          sel_d = CNT_WIDTH'(16);
    endcase
    sel_h = sel_d >> 1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d_d   = per_d_q;
    per_h_d   = per_h_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;

    if (rx_read && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = S_START;
          per_d_d = sel_d;
          per_h_d = sel_h;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == per_h_q - CNT_WIDTH'(1)) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == per_d_q - CNT_WIDTH'(1)) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == per_d_q - CNT_WIDTH'(1)) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
            // A read in the same cycle frees the slot, so the new byte still lands.
            if (!valid_q || rx_read) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      per_d_q   <= CNT_WIDTH'(16);
      per_h_q   <= CNT_WIDTH'(8);
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_d_q   <= per_d_d;
      per_h_q   <= per_h_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       rd_man = 1'b0;
  logic       rd_auto = 1'b0;
  logic       rx_read;
  baud_set_t  baud_setting = BAUD_SET_1000000;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, rx_frame_err, rx_busy;

  assign rx_read = rd_man | rd_auto;

  uart_rx #(.CNT_WIDTH(11)) dut (
    .clk_16mhz    (clk),
    .rstn         (rstn),
    .baud_setting (baud_setting),
    .rx           (rx),
    .rx_read      (rx_read),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #31 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  int         bsq[$];
  int         beq[$];
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 0, m_ovr = 0, m_ferr = 0, m_busy = 0;
  int         cyc = 0, n_chk = 0, n_fail = 0, ferr_cnt = 0;
  bit         auto_en = 0;
  baud_set_t  rates [4] = '{BAUD_SET_9600, BAUD_SET_115200, BAUD_SET_460800, BAUD_SET_1000000};
  logic [7:0] pats [3] = '{8'h00, 8'hFF, 8'h55};

  function automatic int d_of(input baud_set_t s);
    case (s)
      BAUD_SET_9600:    return 1667;
      BAUD_SET_115200:  return 139;
      BAUD_SET_460800:  return 35;
      default:          return 16;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Frame-level model: a frame whose pin start edge is t0 is judged at edge t0+3+H+9D.
  always @(posedge clk) begin : model
    int n;
    bit v, o, f, bz;
    logic [7:0] d;
    n = cyc + 1;
    cyc <= n;
    if (!rstn) begin
      m_data <= 8'h00; m_valid <= 0; m_ovr <= 0; m_ferr <= 0; m_busy <= 0;
      evq.delete(); bsq.delete(); beq.delete();
    end else begin
      v = m_valid; o = m_ovr; d = m_data; f = 0; bz = 0;
      if (rx_read && m_valid) begin v = 0; o = 0; end
      while (evq.size() > 0 && evq[0].edge_n <= n) begin
        if (evq[0].edge_n == n) begin
          if (evq[0].ok) begin
            if (!m_valid || rx_read) begin d = evq[0].b; v = 1; end
            else o = 1;
          end else f = 1;
        end
        void'(evq.pop_front());
      end
      while (beq.size() > 0 && beq[0] <= n) begin
        void'(bsq.pop_front());
        void'(beq.pop_front());
      end
      for (int i = 0; i < bsq.size(); i++)
        if (bsq[i] <= n && n < beq[i]) bz = 1;
      m_data <= d; m_valid <= v; m_ovr <= o; m_ferr <= f; m_busy <= bz;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_data", rx_data, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_overrun", rx_overrun, 0);
      check("rst_ferr", rx_frame_err, 0);
      check("rst_busy", rx_busy, 0);
    end else begin
      check("data", rx_data, m_data);
      check("valid", rx_valid, m_valid);
      check("overrun", rx_overrun, m_ovr);
      check("frame_err", rx_frame_err, m_ferr);
      check("busy", rx_busy, m_busy);
      if (rx_frame_err) ferr_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    rd_auto = auto_en && rx_valid && !rd_auto;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    rd_man = 1'b1;
    wait_cyc(1);
    rd_man = 1'b0;
  endtask

  // low_bits: total bit times the line stays low from the start bit when the stop bit is bad.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int low_bits);
    int d, h, t0;
    ev_t e;
    d = d_of(baud_setting);
    h = d >> 1;
    t0 = cyc;
    e.edge_n = t0 + 3 + h + 9 * d;
    e.b = b;
    e.ok = stop_hi;
    evq.push_back(e);
    bsq.push_back(t0 + 3);
    beq.push_back(stop_hi ? t0 + 3 + h + 9 * d : t0 + 3 + low_bits * d);
    rx = 1'b0;
    wait_cyc(d);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      wait_cyc(d);
    end
    if (stop_hi) begin
      rx = 1'b1;
      wait_cyc(d);
    end else begin
      rx = 1'b0;
      wait_cyc((low_bits - 9) * d);
      rx = 1'b1;
    end
  endtask

  initial begin
    int fc, t0;
    logic [7:0] pb;
    wait_cyc(5);
    rstn = 1'b1;
    wait_cyc(3);
    check("post_rst_busy", rx_busy, 0);
    check("post_rst_data", rx_data, 0);

    // single byte: valid appears exactly 155 cycles after the pin falls
    fork
      send_frame(8'hA5, 1, 10);
      begin
        repeat (154) @(posedge clk);
        #2;
        check("lat_before", rx_valid, 0);
        @(posedge clk);
        #2;
        check("lat_valid", rx_valid, 1);
        check("lat_data", rx_data, 8'hA5);
      end
    join
    pulse_read();
    check("read_clears", rx_valid, 0);

    // all rates, back-to-back with half-bit gaps
    auto_en = 1;
    for (int r = 0; r < 4; r++) begin
      baud_setting = rates[r];
      wait_cyc(4);
      for (int p = 0; p < 3; p++) begin
        send_frame(pats[p], 1, 10);
        wait_cyc(d_of(rates[r]) >> 1);
      end
      wait_cyc(8);
      check("rates_last", rx_data, 8'h55);
      check("rates_ovr", rx_overrun, 0);
    end

    // glitch rejection
    t0 = cyc;
    bsq.push_back(t0 + 3);
    beq.push_back(t0 + 3 + 8);
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(30);
    check("glitch_valid", rx_valid, 0);
    check("glitch_busy", rx_busy, 0);

    // framing error, then break, then recovery
    fc = ferr_cnt;
    send_frame(8'h3C, 0, 10);
    wait_cyc(20);
    check("ferr_count", ferr_cnt - fc, 1);
    check("ferr_data", rx_data, 8'h55);
    fc = ferr_cnt;
    send_frame(8'h00, 0, 40);
    wait_cyc(20);
    check("break_count", ferr_cnt - fc, 1);
    send_frame(8'h5A, 1, 10);
    wait_cyc(20);
    check("resume_data", rx_data, 8'h5A);
    auto_en = 0;
    wait_cyc(4);

    // overrun
    send_frame(8'h11, 1, 10);
    wait_cyc(8);
    send_frame(8'h22, 1, 10);
    wait_cyc(8);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", rx_overrun, 1);
    pulse_read();
    check("ovr_clr_valid", rx_valid, 0);
    check("ovr_clr_flag", rx_overrun, 0);

    // read coincident with the second stop sample
    send_frame(8'h11, 1, 10);
    wait_cyc(8);
    fork
      send_frame(8'h22, 1, 10);
      begin
        repeat (154) @(posedge clk);
        #1;
        rd_man = 1'b1;
        @(posedge clk);
        #1;
        rd_man = 1'b0;
      end
    join
    check("same_data", rx_data, 8'h22);
    check("same_valid", rx_valid, 1);
    check("same_ovr", rx_overrun, 0);
    pulse_read();

    // asynchronous reset during data bit 4
    pb = 8'hC3;
    t0 = cyc;
    bsq.push_back(t0 + 3);
    beq.push_back(t0 + 100000);
    rx = 1'b0;
    wait_cyc(16);
    for (int k = 0; k < 4; k++) begin
      rx = pb[k];
      wait_cyc(16);
    end
    rx = pb[4];
    wait_cyc(8);
    rstn = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_data", rx_data, 0);
    wait_cyc(4);
    rstn = 1'b1;
    wait_cyc(10);
    check("after_rst_busy", rx_busy, 0);
    check("after_rst_valid", rx_valid, 0);
    send_frame(8'hC3, 1, 10);
    wait_cyc(4);
    check("after_rst_rx", rx_data, 8'hC3);
    check("after_rst_rxv", rx_valid, 1);
    pulse_read();
    wait_cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART controller, the receive-side counterpart of the TX path and its baud tick generator. Uses its own bit-period counter, clocked from the 16 MHz core clock and selected by the shared `baud_set_t` setting. Decodes 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) from the asynchronous `rx` pin. Each received byte goes into a one-entry holding register with a valid/read handshake toward the bus side.

## Interface
- `CNT_WIDTH`, default 11: bit-period counter width. Must hold 1666.
- `clk_16mhz`  in  1: 16 MHz core clock. All logic is on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `baud_setting`  in  `baud_set_t`: rate select; latched at start-bit detection.
- `rx`  in  1: serial line, asynchronous, idle high.
- `rx_read`  in  1: single-cycle pulse; consumes the held byte.
- `rx_data`  out  8: last good byte received.
- `rx_valid`  out  1: high while an unread byte is held.
- `rx_overrun`  out  1: sticky; a byte arrived while `rx_valid` was high.
- `rx_frame_err`  out  1: single-cycle pulse; stop bit sampled low.
- `rx_busy`  out  1: high in any state other than IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops (reset value 1). All logic below uses the synchronized `rxs`.
- **Bit period D and half period H = D>>1, by setting:**
  - BAUD_SET_9600: D = 1667, H = 833
  - BAUD_SET_115200: D = 139, H = 69
  - BAUD_SET_460800: D = 35, H = 17
  - BAUD_SET_1000000: D = 16, H = 8
- D and H are latched on entering START. Changing `baud_setting` mid-frame has no effect until the next frame.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** when `rxs == 0`, go to START. Counter `cnt` = 0.
- **START:** `cnt` increments each cycle. At `cnt == H-1`, sample `rxs`:
  - 0: go to DATA, `cnt` = 0, bit index = 0.
  - 1: false start (glitch); return to IDLE with no output activity.
- **DATA:** at `cnt == D-1`, sample `rxs` into the shift register (shift right, new bit into bit 7) and clear `cnt`. After the 8th sample, go to STOP.
- **STOP:** at `cnt == D-1`, sample `rxs`:
  - 1, good frame: go to IDLE.
    - If `rx_valid == 0`, or `rx_read` is high this cycle: load `rx_data` and set `rx_valid`.
    - Otherwise keep the old `rx_data`, drop the new byte, and set `rx_overrun`.
  - 0, framing error: pulse `rx_frame_err`, leave `rx_data`/`rx_valid` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs == 1`, then go to IDLE. A line held low (break) yields exactly one error pulse.
- **Handshake:**
  - `rx_read` while `rx_valid` clears both `rx_valid` and `rx_overrun` next cycle.
  - `rx_read` while `rx_valid == 0` is ignored.
- **Same-cycle read and good-stop:** the new byte loads, `rx_valid` stays 1, no overrun.
- **Reset, asynchronous, any time (including mid-frame):**
  - Outputs: `rx_data` = 0, `rx_valid` = 0, `rx_overrun` = 0, `rx_frame_err` = 0, `rx_busy` = 0.
  - Internal: state = IDLE, synchronizer = 1, `cnt` = 0.
  - The partial frame is discarded. After release, a line sitting low is treated as a start bit.

## Timing
- Pin-to-`rxs` latency is 2 cycles.
- Let cycle 0 be the first cycle in START. Sample points are at cycles:
  - start bit: H
  - data bit k (k = 0..7): H + (k+1)·D
  - stop bit: H + 9·D
- Sampling is centered in each bit ±1 cycle. Tolerates ±4% baud mismatch at D = 16.
- `rx_valid`, `rx_data` and `rx_frame_err` change on the clock edge of the stop sample, so they are visible one cycle after sample cycle H + 9·D.
- `rx_frame_err` is high for exactly 1 cycle.
- `rx_busy` rises the cycle after `rxs` falls in IDLE. It falls with the return to IDLE.
- Back-to-back frames: the next start edge is accepted from the first IDLE cycle. Idle time between frames may be 0.5 bit (the second half of the stop bit).

## Test plan
- **Single byte:** 1 Mbaud, send 0xA5 at 16 clk/bit → `rx_valid` rises 8+144+3 cycles after the pin falls, `rx_data` = 0xA5. `rx_read` → `rx_valid` = 0 next cycle.
- **All rates, back-to-back:** 0x00, 0xFF, 0x55 at all four settings with 0.5-bit gaps, reading each byte → every byte correct, no overrun, no frame error.
- **Glitch rejection:** 1 Mbaud, 5-cycle low pulse on `rx` → state returns to IDLE, `rx_valid` = 0, `rx_busy` pulses only.
- **Framing error and break:**
  - Frame 0x3C with stop bit low → one `rx_frame_err` pulse, `rx_data` unchanged.
  - Line held low for 40 bits → exactly one pulse; the receiver resumes after `rx` returns high.
- **Overrun and same-cycle read:**
  - Two frames 0x11, 0x22 with no read → `rx_data` = 0x11 and `rx_overrun` = 1. `rx_read` clears both flags.
  - Repeat with `rx_read` coincident with the second stop sample → `rx_data` = 0x22, `rx_overrun` = 0.
- **Async reset mid-frame:** assert `rstn` low during data bit 4, then release with `rx` high → all outputs 0, `rx_busy` = 0. The next frame 0xC3 is received correctly.
